// File: rtl/led_matrix_scheduler_if.sv
// Bus between a frame-buffer writer and the 8x8 LED matrix scheduler.
// The bright input exists only when BRIGHTNESS_PWM_EN is defined.
interface led_matrix_scheduler_if #(
    parameter int FW = 2
);
    logic          wr_en;
    logic [FW-1:0] wr_frame;
    logic [2:0]    wr_row;
    logic [7:0]    wr_data;
    logic          run;
    logic          step;
`ifdef BRIGHTNESS_PWM_EN
    logic [2:0]    bright;
`endif
    logic [7:0]    row;
    logic [7:0]    col;
    logic [FW-1:0] frame_idx;
    logic          frame_done;

    modport master (
`ifdef BRIGHTNESS_PWM_EN
        output bright,
`endif
        output wr_en, wr_frame, wr_row, wr_data, run, step,
        input  row, col, frame_idx, frame_done
    );

    modport slave (
`ifdef BRIGHTNESS_PWM_EN
        input  bright,
`endif
        input  wr_en, wr_frame, wr_row, wr_data, run, step,
        output row, col, frame_idx, frame_done
    );
endinterface

// File: rtl/led_matrix_scheduler.sv
// Row-scan sequencer and frame scheduler for an 8x8 LED matrix.
// Optional per-row brightness PWM is enabled by defining BRIGHTNESS_PWM_EN.
module led_matrix_scheduler #(
    parameter int SCAN_DIV   = 1000,
    parameter int FRAME_HOLD = 125,
    parameter int NUM_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    led_matrix_scheduler_if.slave    bus
);
    localparam int FW    = $clog2(NUM_FRAMES);
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int SCW   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int DEPTH = NUM_FRAMES * 8;

    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          done_q, done_d;
    logic [7:0]    col_latch_q, col_latch_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic [7:0]    buf_q [DEPTH];
    logic [7:0]    buf_d [DEPTH];
    logic [FW+2:0] wr_addr;
    logic [2:0]    entry_row;
    logic [7:0]    entry_byte;
`ifdef BRIGHTNESS_PWM_EN
    logic [2:0]    bright_q, bright_d;
    logic [31:0]   pwm_limit;
`endif

    assign wr_addr    = {bus.wr_frame, bus.wr_row};
    // Row about to be entered: row 0 from IDLE, otherwise the successor of the current row.
    assign entry_row  = (state_q == IDLE) ? 3'd0 : row_idx_q + 3'd1;
    assign entry_byte = buf_q[{frame_q, entry_row}];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (bus.wr_en) begin
            buf_d[wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_idx_q   <= '0;
            dwell_cnt_q <= '0;
            scan_cnt_q  <= '0;
            frame_q     <= '0;
            done_q      <= 1'b0;
            col_latch_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
`ifdef BRIGHTNESS_PWM_EN
            bright_q    <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
            col_latch_q <= col_latch_d;
            row_q       <= row_d;
            col_q       <= col_d;
`ifdef BRIGHTNESS_PWM_EN
            bright_q    <= bright_d;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        frame_d     = frame_q;
        done_d      = 1'b0;
        col_latch_d = col_latch_q;
`ifdef BRIGHTNESS_PWM_EN
        bright_d    = bright_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d     = SCAN;
                    row_idx_d   = 3'd0;
                    dwell_cnt_d = '0;
                    col_latch_d = entry_byte;
`ifdef BRIGHTNESS_PWM_EN
                    bright_d    = bus.bright;
`endif
                end else if (bus.step) begin
                    frame_d = frame_q + FW'(1);
                    done_d  = 1'b1;
                end
            end
            SCAN: begin
                if (dwell_cnt_q == DW'(SCAN_DIV - 1)) begin
                    state_d = BLANK;
                    // Frame advance lands on the blank after row 7, even if run drops.
                    if (row_idx_q == 3'd7) begin
                        if (scan_cnt_q == SCW'(FRAME_HOLD - 1)) begin
                            scan_cnt_d = '0;
                            frame_d    = frame_q + FW'(1);
                            done_d     = 1'b1;
                        end else begin
                            scan_cnt_d = scan_cnt_q + SCW'(1);
                        end
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DW'(1);
                end
            end
            BLANK: begin
                dwell_cnt_d = '0;
                if (!bus.run) begin
                    state_d    = IDLE;
                    row_idx_d  = 3'd0;
                    scan_cnt_d = '0;
                end else begin
                    state_d     = SCAN;
                    row_idx_d   = entry_row;
                    col_latch_d = entry_byte;
`ifdef BRIGHTNESS_PWM_EN
                    bright_d    = bus.bright;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state register.
    always_comb begin
        row_d = '0;
        col_d = '0;
`ifdef BRIGHTNESS_PWM_EN
        pwm_limit = ((32'(bright_d) + 32'd1) * 32'(SCAN_DIV)) >> 3;
`endif
        if (state_d == SCAN) begin
            row_d = 8'd1 << row_idx_d;
            col_d = col_latch_d;
`ifdef BRIGHTNESS_PWM_EN
            if (32'(dwell_cnt_d) >= pwm_limit) begin
                col_d = '0;
            end
`endif
        end
    end

    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.frame_idx  = frame_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_led_matrix_scheduler.sv
// Self-checking bench for led_matrix_scheduler: directed scenarios plus random traffic,
// compared every cycle against a time-based reference model.
module tb_led_matrix_scheduler;
    localparam int SD = 4;
    localparam int FH = 2;
    localparam int NF = 4;
    localparam int P  = SD + 1;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    led_matrix_scheduler_if #(.FW(2)) bus ();

    led_matrix_scheduler #(
        .SCAN_DIV(SD), .FRAME_HOLD(FH), .NUM_FRAMES(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: k counts cycles since the scan started; each row owns P cycles,
    // the last of which is blank.
    bit         m_run;
    int         k;
    int         m_frame;
    bit         m_done;
    logic [7:0] m_mem [NF*8];
    logic [7:0] m_latch;
    int         m_bright;

    task automatic model_reset();
        m_run = 0; k = 0; m_frame = 0; m_done = 0; m_latch = 0; m_bright = 7;
        for (int i = 0; i < NF*8; i++) m_mem[i] = 8'h00;
    endtask

    function automatic int cur_bright();
`ifdef BRIGHTNESS_PWM_EN
        return int'(bus.bright);
`else
        return 7;
`endif
    endfunction

    task automatic model_edge();
        m_done = 0;
        if (!m_run) begin
            if (bus.run) begin
                m_run = 1; k = 0;
                m_latch = m_mem[m_frame*8];
                m_bright = cur_bright();
            end else if (bus.step) begin
                m_frame = (m_frame + 1) % NF;
                m_done = 1;
            end
        end else if (k % P == SD) begin
            if (!bus.run) m_run = 0;
            else begin
                k++;
                m_latch = m_mem[m_frame*8 + (k/P)%8];
                m_bright = cur_bright();
            end
        end else begin
            k++;
            if (k % P == SD && (k+1) % (8*P*FH) == 0) begin
                m_frame = (m_frame + 1) % NF;
                m_done = 1;
            end
        end
        if (bus.wr_en) m_mem[int'(bus.wr_frame)*8 + int'(bus.wr_row)] = bus.wr_data;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit lit;
        int lim;
        logic [7:0] er, ec;
        lit = m_run && (k % P != SD);
        lim = ((m_bright + 1) * SD) >> 3;
        er = lit ? (8'd1 << ((k/P) % 8)) : 8'd0;
        ec = (lit && (k % P) < lim) ? m_latch : 8'd0;
        check("row", 32'(bus.row), 32'(er));
        check("col", 32'(bus.col), 32'(ec));
        check("frame_idx", 32'(bus.frame_idx), 32'(m_frame));
        check("frame_done", 32'(bus.frame_done), 32'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    logic [7:0] pat [8];
    int cnt;

    initial begin
        pat[0] = 8'h18; pat[1] = 8'h24; pat[2] = 8'h42; pat[3] = 8'hDB;
        pat[4] = 8'h5A; pat[5] = 8'h42; pat[6] = 8'h42; pat[7] = 8'h7E;
        rst_n = 1'b1;
        bus.wr_en = 0; bus.wr_frame = 0; bus.wr_row = 0; bus.wr_data = 0;
        bus.run = 0; bus.step = 0;
`ifdef BRIGHTNESS_PWM_EN
        bus.bright = 3'd7;
`endif
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_row", 32'(bus.row), 32'h0);
        check("rst_col", 32'(bus.col), 32'h0);
        check("rst_frame_idx", 32'(bus.frame_idx), 32'h0);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;

        // Load frame 0 with the test pattern and frames 1..3 with random bytes.
        for (int r = 0; r < 8; r++) begin
            bus.wr_en = 1; bus.wr_frame = 2'd0; bus.wr_row = 3'(r); bus.wr_data = pat[r];
            tick();
        end
        for (int f = 1; f < NF; f++) begin
            for (int r = 0; r < 8; r++) begin
                bus.wr_frame = 2'(f); bus.wr_row = 3'(r); bus.wr_data = 8'($urandom);
                tick();
            end
        end
        bus.wr_en = 0;

        // Scan start, mid-dwell write to the lit row, frame advances.
        cyc = 0;
        bus.run = 1;
        tick();
        check("first_row", 32'(bus.row), 32'h01);
        check("first_col", 32'(bus.col), 32'h18);
        run_to(6);
        bus.wr_en = 1; bus.wr_frame = 0; bus.wr_row = 3'd1; bus.wr_data = 8'hFF;
        tick();
        bus.wr_en = 0;
        run_to(9);
        check("latched_row", 32'(bus.row), 32'h02);
        check("latched_col", 32'(bus.col), 32'h24);
        run_to(46);
        check("rewritten_row", 32'(bus.row), 32'h02);
        check("rewritten_col", 32'(bus.col), 32'hFF);
        run_to(80);
        check("adv1_done", 32'(bus.frame_done), 32'h1);
        check("adv1_idx", 32'(bus.frame_idx), 32'h1);
        run_to(320);
        check("wrap_done", 32'(bus.frame_done), 32'h1);
        check("wrap_idx", 32'(bus.frame_idx), 32'h0);

        // Stop during row 3, then step and run+step while idle.
        run_to(337);
        bus.run = 0;
        run_to(339);
        check("stop_row_lit", 32'(bus.row), 32'h08);
        run_to(341);
        check("stop_idle_row", 32'(bus.row), 32'h0);
        bus.step = 1;
        tick();
        check("step_done", 32'(bus.frame_done), 32'h1);
        check("step_idx", 32'(bus.frame_idx), 32'h1);
        bus.step = 0;
        tick();
        bus.run = 1; bus.step = 1;
        tick();
        check("runstep_row", 32'(bus.row), 32'h01);
        check("runstep_idx", 32'(bus.frame_idx), 32'h1);
        check("runstep_done", 32'(bus.frame_done), 32'h0);
        bus.step = 0;

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wr_frame = 2'($urandom); bus.wr_row = 3'($urandom); bus.wr_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0) bus.run = ~bus.run;
            bus.step = ($urandom_range(0, 9) == 0);
`ifdef BRIGHTNESS_PWM_EN
            bus.bright = 3'($urandom);
`endif
            tick();
        end
        bus.wr_en = 0; bus.step = 0;
`ifdef BRIGHTNESS_PWM_EN
        bus.bright = 3'd7;
`endif

        // Asynchronous reset while a row is lit.
        bus.run = 1;
        cnt = 0;
        while (!(m_run && k % P != SD) && cnt < 20) begin tick(); cnt++; end
        check("reach_scan", 32'(m_run && k % P != SD), 32'h1);
        bus.run = 0;
        rst_n = 1'b0;
        #1;
        check("async_rst_row", 32'(bus.row), 32'h0);
        check("async_rst_col", 32'(bus.col), 32'h0);
        check("async_rst_idx", 32'(bus.frame_idx), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        bus.run = 1;
        tick();
        check("post_rst_row", 32'(bus.row), 32'h01);
        check("post_rst_col", 32'(bus.col), 32'h00);
        for (int n = 0; n < 45; n++) tick();

`ifdef BRIGHTNESS_PWM_EN
        bus.run = 0;
        cnt = 0;
        while (m_run && cnt < 40) begin tick(); cnt++; end
        check("pwm_idle", 32'(m_run), 32'h0);
        bus.wr_en = 1; bus.wr_data = 8'hFF;
        for (int a = 0; a < NF*8; a++) begin
            bus.wr_frame = 2'(a / 8); bus.wr_row = 3'(a % 8);
            tick();
        end
        bus.wr_en = 0;
        bus.bright = 3'd3; bus.run = 1;
        cnt = 0;
        for (int n = 0; n < 4; n++) begin tick(); if (bus.col != 0) cnt++; end
        check("pwm_b3_cycles", 32'(cnt), 32'd2);
        bus.bright = 3'd7;
        tick();
        cnt = 0;
        for (int n = 0; n < 4; n++) begin tick(); if (bus.col != 0) cnt++; end
        check("pwm_b7_cycles", 32'(cnt), 32'd4);
        bus.bright = 3'd0;
        tick();
        cnt = 0;
        for (int n = 0; n < 4; n++) begin tick(); if (bus.col != 0) cnt++; end
        check("pwm_b0_cycles", 32'(cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
